// File: rtl/comb_sweep_ctrl.sv
// Self-test sequencer: walks {A,B,C} through 0..7, samples Y after a settle
// interval, and reports the measured truth table against an expected pattern.
module comb_sweep_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [7:0] EXPECT = 8'h42
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       CONT,
  input  logic       Y_I,
  output logic       A_O,
  output logic       B_O,
  output logic       C_O,
  output logic [7:0] TT,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] ERR_IDX,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, CHECK, DONE_ST} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] settle, settle_nx;
  logic [7:0] wtt, wtt_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [2:0] widx, widx_nx;
  logic       seen, seen_nx;
  logic [7:0] tt_nx;
  logic       pass_nx, done_nx;
  logic [3:0] err_cnt_nx;
  logic [2:0] err_idx_nx;
  logic       begin_sweep;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START && !ABORT) state_nx = WAIT;
      WAIT:    if (ABORT) state_nx = IDLE;
               else if (settle == 4'd0) state_nx = SAMPLE;
      SAMPLE:  if (ABORT) state_nx = IDLE;
               else if (idx == 3'd7) state_nx = CHECK;
               else state_nx = WAIT;
      CHECK:   if (ABORT) state_nx = IDLE;
               else if (CONT) state_nx = WAIT;
               else state_nx = DONE_ST;
      DONE_ST: if (ABORT) state_nx = IDLE;
               else if (START) state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // A new sweep starts from IDLE/DONE_ST on START, or back-to-back out of CHECK.
  assign begin_sweep = !ABORT &&
    ((((state == IDLE) || (state == DONE_ST)) && START) || ((state == CHECK) && CONT));

  always_comb begin
    idx_nx     = idx;
    settle_nx  = settle;
    wtt_nx     = wtt;
    wcnt_nx    = wcnt;
    widx_nx    = widx;
    seen_nx    = seen;
    tt_nx      = TT;
    pass_nx    = PASS;
    err_cnt_nx = ERR_CNT;
    err_idx_nx = ERR_IDX;
    done_nx    = 1'b0;

    if (ABORT && state != IDLE) begin
      idx_nx = 3'd0;
    end else begin
      case (state)
        WAIT: if (settle != 4'd0) settle_nx = settle - 4'd1;
        SAMPLE: begin
          wtt_nx[idx] = Y_I;
          if (Y_I != EXPECT[idx]) begin
            wcnt_nx = wcnt + 4'd1;
            if (!seen) begin
              widx_nx = idx;
              seen_nx = 1'b1;
            end
          end
          if (idx != 3'd7) begin
            idx_nx    = idx + 3'd1;
            settle_nx = SETTLE_LD;
          end
        end
        CHECK: begin
          tt_nx      = wtt;
          pass_nx    = (wtt == EXPECT);
          err_cnt_nx = wcnt;
          err_idx_nx = widx;
          done_nx    = 1'b1;
        end
        DONE_ST: done_nx = !START;
        default: ;
      endcase

      if (begin_sweep) begin
        idx_nx    = 3'd0;
        settle_nx = SETTLE_LD;
        wtt_nx    = 8'h00;
        wcnt_nx   = 4'd0;
        widx_nx   = 3'd0;
        seen_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx     <= 3'd0;
      settle  <= 4'd0;
      wtt     <= 8'h00;
      wcnt    <= 4'd0;
      widx    <= 3'd0;
      seen    <= 1'b0;
      TT      <= 8'h00;
      PASS    <= 1'b0;
      ERR_CNT <= 4'd0;
      ERR_IDX <= 3'd0;
      DONE    <= 1'b0;
    end else begin
      idx     <= idx_nx;
      settle  <= settle_nx;
      wtt     <= wtt_nx;
      wcnt    <= wcnt_nx;
      widx    <= widx_nx;
      seen    <= seen_nx;
      TT      <= tt_nx;
      PASS    <= pass_nx;
      ERR_CNT <= err_cnt_nx;
      ERR_IDX <= err_idx_nx;
      DONE    <= done_nx;
    end
  end

  // idx is held at 0 whenever the controller is idle, so it drives the vector directly.
  assign {A_O, B_O, C_O} = idx;
  assign BUSY = (state == WAIT) || (state == SAMPLE) || (state == CHECK);

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: instance 0 uses SETTLE=2, instance 1 uses SETTLE=1
// with continuous sweeps; a cycle-level model tracks both.
module tb_comb_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_i [2];
  logic       abort_i [2];
  logic       cont_i  [2];
  logic       y_i     [2];
  logic       a_o [2], b_o [2], c_o [2];
  logic [7:0] tt_o    [2];
  logic       pass_o  [2];
  logic [3:0] cnt_o   [2];
  logic [2:0] idx_o   [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  int         mode    [2];
  logic       frc = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // mode 0: good, 1: stuck at 0, 2: inverted, 3: good except vector 5 forced to 1 when frc
  function automatic logic yfn(int md, int k, logic f);
    logic [7:0] e;
    e = 8'h42;
    case (md)
      1:       return 1'b0;
      2:       return ~e[k];
      3:       return (k == 5 && f) ? 1'b1 : e[k];
      default: return e[k];
    endcase
  endfunction

  assign y_i[0] = yfn(mode[0], int'({a_o[0], b_o[0], c_o[0]}), 1'b0);
  assign y_i[1] = yfn(mode[1], int'({a_o[1], b_o[1], c_o[1]}), frc);

  comb_sweep_ctrl #(.SETTLE(2), .EXPECT(8'h42)) u0 (
    .CLK(clk), .RST(rst), .START(start_i[0]), .ABORT(abort_i[0]), .CONT(cont_i[0]),
    .Y_I(y_i[0]), .A_O(a_o[0]), .B_O(b_o[0]), .C_O(c_o[0]), .TT(tt_o[0]),
    .PASS(pass_o[0]), .ERR_CNT(cnt_o[0]), .ERR_IDX(idx_o[0]), .BUSY(busy_o[0]),
    .DONE(done_o[0]));

  comb_sweep_ctrl #(.SETTLE(1), .EXPECT(8'h42)) u1 (
    .CLK(clk), .RST(rst), .START(start_i[1]), .ABORT(abort_i[1]), .CONT(cont_i[1]),
    .Y_I(y_i[1]), .A_O(a_o[1]), .B_O(b_o[1]), .C_O(c_o[1]), .TT(tt_o[1]),
    .PASS(pass_o[1]), .ERR_CNT(cnt_o[1]), .ERR_IDX(idx_o[1]), .BUSY(busy_o[1]),
    .DONE(done_o[1]));

  // model: st 0 idle, 1 sweeping (t = edges since the start edge), 2 result held
  int         m_st [2];
  int         m_t  [2];
  logic [7:0] m_wtt[2];
  logic [7:0] m_tt [2];
  logic       m_pass[2];
  int         m_cnt[2];
  int         m_idx[2];
  logic       m_done[2];
  int         m_abc[2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_t[i] = 0; m_wtt[i] = 8'h00; m_tt[i] = 8'h00; m_pass[i] = 1'b0;
      m_cnt[i] = 0; m_idx[i] = 0; m_done[i] = 1'b0; m_abc[i] = 0;
    end
  endtask

  task automatic m_step(int i);
    int s1;
    int k;
    logic [7:0] diff;
    s1 = (i == 0) ? 3 : 2;
    if (m_st[i] != 0 && abort_i[i]) begin
      m_st[i] = 0; m_done[i] = 1'b0; m_abc[i] = 0;
    end else if (m_st[i] != 1) begin
      if (start_i[i] && !abort_i[i]) begin
        m_st[i] = 1; m_t[i] = 0; m_wtt[i] = 8'h00; m_done[i] = 1'b0; m_abc[i] = 0;
      end
    end else begin
      m_t[i]++;
      m_done[i] = 1'b0;
      if (m_t[i] % s1 == 0 && m_t[i] <= 8 * s1) begin
        k = m_t[i] / s1 - 1;
        m_wtt[i][k] = yfn(mode[i], k, frc);
      end
      if (m_t[i] == 8 * s1 + 1) begin
        diff = m_wtt[i] ^ 8'h42;
        m_tt[i]   = m_wtt[i];
        m_cnt[i]  = $countones(diff);
        m_pass[i] = (diff == 8'h00);
        m_idx[i]  = 0;
        for (int b = 7; b >= 0; b--) if (diff[b]) m_idx[i] = b;
        m_done[i] = 1'b1;
        if (cont_i[i]) begin m_t[i] = 0; m_wtt[i] = 8'h00; end
        else m_st[i] = 2;
      end
      m_abc[i] = (m_st[i] == 1 && m_t[i] < 8 * s1) ? m_t[i] / s1 : 7;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else for (int i = 0; i < 2; i++) m_step(i);
  end

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.abc", i),  int'({a_o[i], b_o[i], c_o[i]}), m_abc[i]);
      chk($sformatf("u%0d.busy", i), int'(busy_o[i]), int'(m_st[i] == 1));
      chk($sformatf("u%0d.done", i), int'(done_o[i]), int'(m_done[i]));
      chk($sformatf("u%0d.tt", i),   int'(tt_o[i]),   int'(m_tt[i]));
      chk($sformatf("u%0d.pass", i), int'(pass_o[i]), int'(m_pass[i]));
      chk($sformatf("u%0d.cnt", i),  int'(cnt_o[i]),  m_cnt[i]);
      chk($sformatf("u%0d.idx", i),  int'(idx_o[i]),  m_idx[i]);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic result0(string tag, int tt, int ps, int cnt, int idx);
    chk({tag, ".tt"},   int'(tt_o[0]),   tt);
    chk({tag, ".pass"}, int'(pass_o[0]), ps);
    chk({tag, ".cnt"},  int'(cnt_o[0]),  cnt);
    chk({tag, ".idx"},  int'(idx_o[0]),  idx);
  endtask

  // Pulses START on u0 and runs to the edge that should raise DONE (edge 25).
  task automatic sweep0(string tag);
    start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    for (int e = 0; e < 25; e++) begin
      if (mode[0] == 2 && e < 24) chk({tag, ".abc_seq"}, int'({a_o[0], b_o[0], c_o[0]}), e / 3);
      if (e == 24) begin
        chk({tag, ".done_e24"}, int'(done_o[0]), 0);
        chk({tag, ".busy_e24"}, int'(busy_o[0]), 1);
      end
      step();
    end
    chk({tag, ".done_e25"}, int'(done_o[0]), 1);
    chk({tag, ".busy_e25"}, int'(busy_o[0]), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; abort_i[i] = 1'b0; cont_i[i] = 1'b0; mode[i] = 0;
    end
    m_reset();
    step(); step();
    rst = 1'b0;
    step();
    result0("reset", 8'h00, 0, 0, 0);
    chk("reset.busy", int'(busy_o[0]), 0);

    mode[0] = 0; sweep0("good");  result0("good", 8'h42, 1, 0, 0);
    mode[0] = 1; sweep0("stuck"); result0("stuck", 8'h00, 0, 2, 1);
    mode[0] = 2; sweep0("inv");   result0("inv", 8'hBD, 0, 8, 0);
    mode[0] = 0; sweep0("good2"); result0("good2", 8'h42, 1, 0, 0);

    // second sweep: stray START mid-sweep, then ABORT+START during vector 4
    start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    repeat (4) step();
    start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    repeat (7) step();
    chk("abort.abc_before", int'({a_o[0], b_o[0], c_o[0]}), 4);
    abort_i[0] = 1'b1; start_i[0] = 1'b1; step();
    abort_i[0] = 1'b0; start_i[0] = 1'b0;
    chk("abort.abc",  int'({a_o[0], b_o[0], c_o[0]}), 0);
    chk("abort.done", int'(done_o[0]), 0);
    chk("abort.busy", int'(busy_o[0]), 0);
    result0("abort", 8'h42, 1, 0, 0);
    repeat (3) step();
    chk("abort.idle", int'(busy_o[0]), 0);

    // asynchronous reset at vector 3
    start_i[0] = 1'b1; step(); start_i[0] = 1'b0;
    repeat (10) step();
    chk("rst.abc_before", int'({a_o[0], b_o[0], c_o[0]}), 3);
    rst = 1'b1; #1;
    result0("rst", 8'h00, 0, 0, 0);
    chk("rst.abc",  int'({a_o[0], b_o[0], c_o[0]}), 0);
    chk("rst.busy", int'(busy_o[0]), 0);
    chk("rst.done", int'(done_o[0]), 0);
    step(); rst = 1'b0;
    repeat (2) step();
    chk("rst.idle_busy", int'(busy_o[0]), 0);
    chk("rst.idle_abc",  int'({a_o[0], b_o[0], c_o[0]}), 0);

    // u1: SETTLE=1, continuous sweeps, fault on vector 5 in the second pass
    mode[1] = 3; cont_i[1] = 1'b1;
    start_i[1] = 1'b1; step(); start_i[1] = 1'b0;
    repeat (16) step();
    chk("cont.done_e16", int'(done_o[1]), 0);
    step();
    chk("cont.done_e17", int'(done_o[1]), 1);
    chk("cont.tt1",      int'(tt_o[1]), 8'h42);
    chk("cont.pass1",    int'(pass_o[1]), 1);
    frc = 1'b1;
    step();
    chk("cont.done_e18", int'(done_o[1]), 0);
    chk("cont.busy_e18", int'(busy_o[1]), 1);
    chk("cont.tt_hold",  int'(tt_o[1]), 8'h42);
    repeat (15) step();
    chk("cont.done_e33", int'(done_o[1]), 0);
    step();
    chk("cont.done_e34", int'(done_o[1]), 1);
    chk("cont.tt2",      int'(tt_o[1]), 8'h62);
    chk("cont.cnt2",     int'(cnt_o[1]), 1);
    chk("cont.idx2",     int'(idx_o[1]), 5);
    chk("cont.pass2",    int'(pass_o[1]), 0);
    frc = 1'b0;
    repeat (6) step();
    cont_i[1] = 1'b0;
    repeat (10) step();
    chk("cont.done_e50", int'(done_o[1]), 0);
    step();
    chk("cont.done_e51", int'(done_o[1]), 1);
    chk("cont.busy_e51", int'(busy_o[1]), 0);
    chk("cont.tt3",      int'(tt_o[1]), 8'h42);
    repeat (2) step();
    chk("cont.done_hold", int'(done_o[1]), 1);
    chk("cont.busy_hold", int'(busy_o[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
